// File: rtl/seg7_mux_reader.sv
// rtl/seg7_mux_reader.sv - recovers BCD digits from a scanned 4-digit 7-segment display bus
module seg7_mux_reader #(
    parameter int SETTLE_CYCLES = 4,
    parameter int TIMEOUT       = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg_in,
    input  logic       dp_in,
    input  logic [3:0] sel_in,
    input  logic       seg_active_low,
    input  logic       sel_active_low,
    output logic [3:0] min_u,
    output logic [3:0] min_d,
    output logic [3:0] hrs_u,
    output logic [3:0] hrs_d,
    output logic [3:0] dp_bits,
    output logic       frame_valid,
    output logic       frame_strobe,
    output logic       time_valid,
    output logic       decode_err,
    output logic       sel_err,
    output logic       stale
);
    localparam int CW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ARM = CW'(SETTLE_CYCLES - 2);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);
    localparam logic [TW-1:0] TMO_ARM = TW'(TIMEOUT - 1);

    // returns {valid, digit}
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h3F: decode = 5'h10;
            7'h06: decode = 5'h11;
            7'h5B: decode = 5'h12;
            7'h4F: decode = 5'h13;
            7'h66: decode = 5'h14;
            7'h6D: decode = 5'h15;
            7'h7C: decode = 5'h16;
            7'h07: decode = 5'h17;
            7'h7F: decode = 5'h18;
            7'h67: decode = 5'h19;
            default: decode = 5'h00;
        endcase
    endfunction

    logic [6:0]      seg_s1_q, seg_s2_q;
    logic            dp_s1_q, dp_s2_q;
    logic [3:0]      sel_s1_q, sel_s2_q;
    logic [11:0]     pat_q;
    logic [CW-1:0]   count_q, count_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [3:0][3:0] slot_q, slot_d;
    logic [3:0]      dpw_q, dpw_d;
    logic [3:0]      mask_q, mask_d;
    logic [3:0][3:0] dig_q, dig_d;
    logic [3:0]      dpo_q, dpo_d;
    logic            valid_q, valid_d, strobe_q, strobe_d, tv_q, tv_d;
    logic            derr_q, derr_d, serr_q, serr_d, stale_q, stale_d;

    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  sel_n;
    logic [11:0] pat;
    logic [4:0]  dec;
    logic        same, capture, sel_ok, good, publish, timeout_hit;

    always_comb begin
        seg_n   = seg_s2_q ^ {7{seg_active_low}};
        dp_n    = dp_s2_q ^ seg_active_low;
        sel_n   = sel_s2_q ^ {4{sel_active_low}};
        pat     = {sel_n, dp_n, seg_n};
        same    = (pat == pat_q);
        capture = same && (count_q == CNT_ARM);
        dec     = decode(seg_n);
        sel_ok  = $onehot(sel_n);
        good    = capture && sel_ok && dec[4];
        publish = good && ((mask_q | sel_n) == 4'hF);
        // a good capture on the timeout edge keeps the bus alive
        timeout_hit = !good && (timer_q == TMO_ARM);

        count_d = same ? ((count_q == CNT_MAX) ? count_q : count_q + CW'(1)) : '0;
        timer_d = good ? '0 : ((timer_q == TMO_MAX) ? timer_q : timer_q + TW'(1));
        slot_d  = slot_q;
        dpw_d   = dpw_q;
        mask_d  = good ? (mask_q | sel_n) : mask_q;
        for (int i = 0; i < 4; i++) begin
            if (good && sel_n[i]) begin
                slot_d[i] = dec[3:0];
                dpw_d[i]  = dp_n;
            end
        end

        dig_d    = dig_q;
        dpo_d    = dpo_q;
        valid_d  = valid_q;
        tv_d     = tv_q;
        stale_d  = stale_q;
        strobe_d = publish;
        derr_d   = capture && sel_ok && !dec[4];
        serr_d   = capture && !sel_ok;
        if (publish) begin
            dig_d   = slot_d;
            dpo_d   = dpw_d;
            valid_d = 1'b1;
            stale_d = 1'b0;
            mask_d  = '0;
            tv_d    = (slot_d[1] <= 4'd5) && (slot_d[3] <= 4'd2) &&
                      ((slot_d[3] < 4'd2) || (slot_d[2] <= 4'd3));
        end else if (timeout_hit) begin
            stale_d = 1'b1;
            valid_d = 1'b0;
            mask_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_s1_q <= '0; seg_s2_q <= '0;
            dp_s1_q  <= 1'b0; dp_s2_q <= 1'b0;
            sel_s1_q <= '0; sel_s2_q <= '0;
            pat_q    <= '0;
            count_q  <= '0;
            timer_q  <= '0;
            slot_q   <= '0;
            dpw_q    <= '0;
            mask_q   <= '0;
            dig_q    <= '0;
            dpo_q    <= '0;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
            tv_q     <= 1'b0;
            derr_q   <= 1'b0;
            serr_q   <= 1'b0;
            stale_q  <= 1'b0;
        end else begin
            seg_s1_q <= seg_in; seg_s2_q <= seg_s1_q;
            dp_s1_q  <= dp_in;  dp_s2_q  <= dp_s1_q;
            sel_s1_q <= sel_in; sel_s2_q <= sel_s1_q;
            pat_q    <= pat;
            count_q  <= count_d;
            timer_q  <= timer_d;
            slot_q   <= slot_d;
            dpw_q    <= dpw_d;
            mask_q   <= mask_d;
            dig_q    <= dig_d;
            dpo_q    <= dpo_d;
            valid_q  <= valid_d;
            strobe_q <= strobe_d;
            tv_q     <= tv_d;
            derr_q   <= derr_d;
            serr_q   <= serr_d;
            stale_q  <= stale_d;
        end
    end

    assign min_u        = dig_q[0];
    assign min_d        = dig_q[1];
    assign hrs_u        = dig_q[2];
    assign hrs_d        = dig_q[3];
    assign dp_bits      = dpo_q;
    assign frame_valid  = valid_q;
    assign frame_strobe = strobe_q;
    assign time_valid   = tv_q;
    assign decode_err   = derr_q;
    assign sel_err      = serr_q;
    assign stale        = stale_q;
endmodule

// File: tb/tb_seg7_mux_reader.sv
// tb/tb_seg7_mux_reader.sv - directed self-checking bench for seg7_mux_reader
module tb_seg7_mux_reader;
    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] seg_in;
    logic       dp_in;
    logic [3:0] sel_in;
    logic       seg_active_low, sel_active_low;
    logic [3:0] min_u, min_d, hrs_u, hrs_d, dp_bits;
    logic       frame_valid, frame_strobe, time_valid, decode_err, sel_err, stale;

    int total = 0;
    int bad   = 0;
    int n_strobe = 0, n_derr = 0, n_serr = 0;
    int s0, d0, e0;
    logic inv = 1'b0;
    logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7C, 7'h07, 7'h7F, 7'h67};

    seg7_mux_reader #(.SETTLE_CYCLES(4), .TIMEOUT(256)) dut (
        .clk(clk), .reset(reset), .seg_in(seg_in), .dp_in(dp_in), .sel_in(sel_in),
        .seg_active_low(seg_active_low), .sel_active_low(sel_active_low),
        .min_u(min_u), .min_d(min_d), .hrs_u(hrs_u), .hrs_d(hrs_d), .dp_bits(dp_bits),
        .frame_valid(frame_valid), .frame_strobe(frame_strobe), .time_valid(time_valid),
        .decode_err(decode_err), .sel_err(sel_err), .stale(stale)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (frame_strobe) n_strobe++;
            if (decode_err)   n_derr++;
            if (sel_err)      n_serr++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] sel, input logic [6:0] seg, input logic dp, input int n);
        sel_in = inv ? ~sel : sel;
        seg_in = inv ? ~seg : seg;
        dp_in  = inv ? ~dp : dp;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input int hd, input int hu, input int md, input int mu);
        drive(4'b1000, segtab[hd], 1'b0, 32);
        drive(4'b0100, segtab[hu], 1'b1, 32);
        drive(4'b0010, segtab[md], 1'b0, 32);
        drive(4'b0001, segtab[mu], 1'b0, 32);
    endtask

    task automatic snap();
        s0 = n_strobe; d0 = n_derr; e0 = n_serr;
    endtask

    initial begin
        reset = 1'b1; seg_in = '0; dp_in = 1'b0; sel_in = '0;
        seg_active_low = 1'b0; sel_active_low = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_frame_valid", frame_valid, 0);
        check("rst_digits", {hrs_d, hrs_u, min_d, min_u}, 16'h0000);
        check("rst_flags", {frame_strobe, time_valid, decode_err, sel_err, stale}, 5'b0);
        reset = 1'b0;

        snap();
        scan(1, 2, 3, 4);
        check("s1234_strobes", n_strobe - s0, 1);
        check("s1234_digits", {hrs_d, hrs_u, min_d, min_u}, 16'h1234);
        check("s1234_dp", dp_bits, 4'b0100);
        check("s1234_tv_fv", {time_valid, frame_valid, stale}, 3'b110);
        check("s1234_errs", (n_derr - d0) + (n_serr - e0), 0);

        inv = 1'b1; seg_active_low = 1'b1; sel_active_low = 1'b1;
        snap();
        scan(1, 2, 3, 4);
        check("inv_strobes", n_strobe - s0, 1);
        check("inv_digits", {hrs_d, hrs_u, min_d, min_u}, 16'h1234);
        check("inv_dp_tv", {dp_bits, time_valid, frame_valid}, 6'b0100_11);
        check("inv_errs", (n_derr - d0) + (n_serr - e0), 0);

        inv = 1'b0; seg_active_low = 1'b0; sel_active_low = 1'b0;
        snap();
        drive(4'b1000, segtab[1], 1'b0, 32);
        drive(4'b0100, segtab[2], 1'b1, 32);
        drive(4'b0010, segtab[3], 1'b0, 32);
        drive(4'b0001, segtab[8], 1'b0, 2);
        drive(4'b1000, segtab[1], 1'b0, 32);
        check("glitch_no_strobe", n_strobe - s0, 0);
        check("glitch_no_err", (n_derr - d0) + (n_serr - e0), 0);
        check("glitch_digits", {hrs_d, hrs_u, min_d, min_u}, 16'h1234);
        drive(4'b0001, segtab[5], 1'b0, 32);
        check("glitch_then_strobe", n_strobe - s0, 1);
        check("glitch_then_min_u", min_u, 4'd5);

        snap();
        drive(4'b1000, segtab[1], 1'b0, 32);
        drive(4'b0100, 7'h7E, 1'b0, 10);
        drive(4'b0010, segtab[3], 1'b0, 32);
        drive(4'b0001, segtab[4], 1'b0, 32);
        check("derr_count", n_derr - d0, 1);
        check("derr_no_strobe", n_strobe - s0, 0);
        drive(4'b0100, segtab[2], 1'b1, 32);
        check("derr_then_strobe", n_strobe - s0, 1);
        check("derr_then_digits", {hrs_d, hrs_u, min_d, min_u}, 16'h1234);

        snap();
        drive(4'b0011, segtab[1], 1'b0, 10);
        check("serr_count", n_serr - e0, 1);
        check("serr_no_derr", n_derr - d0, 0);

        drive(4'b0000, 7'h00, 1'b0, 300);
        check("stale_set", {stale, frame_valid}, 2'b10);
        check("stale_hold_digits", {hrs_d, hrs_u, min_d, min_u}, 16'h1234);
        snap();
        scan(1, 2, 3, 4);
        check("resume_strobe", n_strobe - s0, 1);
        check("resume_flags", {stale, frame_valid, time_valid}, 3'b011);

        scan(2, 4, 6, 0);
        check("s2460_digits", {hrs_d, hrs_u, min_d, min_u}, 16'h2460);
        check("s2460_tv", time_valid, 0);
        scan(2, 3, 5, 9);
        check("s2359_digits", {hrs_d, hrs_u, min_d, min_u}, 16'h2359);
        check("s2359_tv", time_valid, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
